ref_lvl_ctrl: RTL and testbench
===============================

// Module: ref_lvl_ctrl
// PURPOSE
//  Decision-directed reference-level controller for the 4-PAM slicer/mapper path.
//  Averages |slicer input| over a block of 2^LOG2_N symbols and emits ref_lvl (2s16).
//  For levels +-a, +-3a, mean|x| = 2a, which is both the inner/outer decision
//  threshold and the reference level the mapper_ref/slicer stage consumes.
//  Sits after the matched filter, beside the slicer; sequences acquisition and tracking.
// PARAMETERS
//  LOG2_N    4         log2 of symbols averaged per estimate (valid range 2..10)
//  REF_INIT  18'sd43690 ref_lvl reset/default value, 2s16 (full-scale 4-PAM mean|x|)
//  ALPHA_SH  3         IIR update shift; used only when REF_LVL_IIR_EN is defined
// PORTS
//  clk        in   1   system clock
//  reset      in   1   synchronous, active-low reset
//  sym_en     in   1   symbol strobe, 1-cycle pulse; consecutive pulses >=2 clk apart
//  dec_in     in   18  signed 1s17 slicer input sample, valid when sym_en=1
//  start      in   1   begin acquisition (level-sampled in IDLE only)
//  track      in   1   1: re-acquire continuously; 0: return to IDLE after one estimate
//  ref_lvl    out  18  signed 2s16 reference level (mean |dec_in|, >>1 from 1s17)
//  ref_valid  out  1   high once at least one estimate has been loaded
//  upd_pulse  out  1   1-cycle pulse in the cycle ref_lvl changes
//  busy       out  1   high in ACQ and UPD states
// BEHAVIOUR
//  Reset (reset=0 at posedge): state=IDLE, acc=0, cnt=0, ref_lvl=REF_INIT,
//   ref_valid=0, upd_pulse=0, busy=0. Applies mid-operation; partial block discarded.
//  Abs: |dec_in|, with -131072 saturated to 131071 (17-bit unsigned result).
//  acc: unsigned, 17+LOG2_N bits, cannot overflow. cnt: LOG2_N bits.
//  FSM:
//   IDLE: busy=0. start=1 -> ACQ, acc<=0, cnt<=0. sym_en ignored.
//   ACQ : busy=1. On sym_en: acc<=acc+|dec_in|, cnt<=cnt+1.
//         sym_en with cnt=2^LOG2_N-1 -> UPD (final sample included in acc).
//         start ignored in ACQ.
//   UPD : one cycle. new = acc>>LOG2_N (1s17 mean); ref_lvl updated (see CONFIG),
//         visible at the next edge together with upd_pulse=1 and ref_valid=1.
//         acc<=0, cnt<=0. track=1 -> ACQ, else -> IDLE.
//  Latency: final sym_en edge -> UPD; ref_lvl/upd_pulse valid 2 clk after final sym_en.
//  No sym_en can arrive during UPD (strobe spacing >=2); no overlap handling needed.
//  ref_lvl holds its value in IDLE and during ACQ; ref_valid stays 1 until reset.
//  track is sampled only in UPD; changing it mid-block does not truncate the block.
//  All outputs are registered; no combinational input-to-output paths.
// CONFIGURATION
//  REF_LVL_IIR_EN defined: ref_lvl <= ref_lvl + ((new>>>1) - ref_lvl) >>> ALPHA_SH,
//   computed at 19 bits, then saturated to 18 bits. The first update after reset
//   loads new>>>1 directly, bypassing the IIR.
//  Not defined: ref_lvl <= new>>>1 (block-average replacement); ALPHA_SH unused.
// TESTING
//  1 LOG2_N=4, start, 16 sym_en with dec_in=131071 -> ref_lvl=65535,
//    upd_pulse once, 2 clk after the 16th strobe.
//  2 16 symbols of equal mix {131071,43691,-43691,-131072} -> ref_lvl=43690,
//    ref_valid=1; track=0 -> IDLE, busy=0.
//  3 16 symbols all -131072 -> abs saturates, ref_lvl=65535 (not 65536/negative).
//  4 Assert reset after 9 strobes in ACQ -> ref_lvl=43690, ref_valid=0; with no start,
//    further sym_en has no effect.
//  5 track=1, blocks of 43691 then 131071 -> ref_lvl 21845 then 65535,
//    two upd_pulses 16 symbols apart, busy stays high.
//  6 REF_LVL_IIR_EN, ALPHA_SH=3: first block 43691, second block 131071
//    -> 21845 then 21845+(65535-21845)>>>3 = 27306.

Source files
------------

// File: rtl/ref_lvl_ctrl.sv
// Decision-directed 4-PAM reference-level controller: block-averages |dec_in| and publishes ref_lvl (2s16).
// Optional macro REF_LVL_IIR_EN: smooth successive estimates with a first-order IIR instead of replacing them.
//
// state | meaning
// IDLE  | waiting for start, ref_lvl held
// ACQ   | accumulating |dec_in| over 2^LOG2_N strobes
// UPD   | one cycle: load new reference, then re-acquire or go idle
module ref_lvl_ctrl #(
  parameter int                 LOG2_N   = 4,
  parameter logic signed [17:0] REF_INIT = 18'sd43690,
  parameter int                 ALPHA_SH = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               sym_en,
  input  logic signed [17:0] dec_in,
  input  logic               start,
  input  logic               track,
  output logic signed [17:0] ref_lvl,
  output logic               ref_valid,
  output logic               upd_pulse,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, ACQ, UPD} state_t;

  state_t              state;
  logic [16+LOG2_N:0]  acc;
  logic [LOG2_N-1:0]   cnt;

  logic [17:0]         neg_in;
  logic [16:0]         mag;
  logic [16:0]         mean;
  logic signed [17:0]  half;
  logic signed [17:0]  next_ref;

  // -131072 has no positive 18-bit counterpart; clamp it to the largest magnitude
  always_comb begin
    neg_in = -dec_in;
    if (dec_in == 18'sh20000)
      mag = 17'h1FFFF;
    else if (dec_in[17])
      mag = neg_in[16:0];
    else
      mag = dec_in[16:0];
  end

  assign mean = acc[16+LOG2_N:LOG2_N];
  assign half = {2'b00, mean[16:1]};

`ifdef REF_LVL_IIR_EN
  logic signed [18:0] diff;
  logic signed [18:0] step;
  logic signed [18:0] sum19;
  logic signed [17:0] sat_ref;

  always_comb begin
    diff  = {half[17], half} - {ref_lvl[17], ref_lvl};
    step  = diff >>> ALPHA_SH;
    sum19 = {ref_lvl[17], ref_lvl} + step;
    if (sum19[18] != sum19[17])
      sat_ref = sum19[18] ? 18'sh20000 : 18'sh1FFFF;
    else
      sat_ref = sum19[17:0];
  end

  // first estimate after reset has no history worth filtering against
  assign next_ref = ref_valid ? sat_ref : half;
`else
  logic unused_alpha;
  assign unused_alpha = (ALPHA_SH != 0);
  assign next_ref     = half;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      ref_lvl   <= REF_INIT;
      ref_valid <= 1'b0;
      upd_pulse <= 1'b0;
      busy      <= 1'b0;
    end else begin
      upd_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= ACQ;
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
          end
        end
        ACQ: begin
          if (sym_en) begin
            acc <= acc + {{LOG2_N{1'b0}}, mag};
            cnt <= cnt + 1'b1;
            if (cnt == '1)
              state <= UPD;
          end
        end
        UPD: begin
          ref_lvl   <= next_ref;
          ref_valid <= 1'b1;
          upd_pulse <= 1'b1;
          acc       <= '0;
          cnt       <= '0;
          if (track) begin
            state <= ACQ;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ref_lvl_ctrl.sv
// Bench for ref_lvl_ctrl: directed and random 16-symbol blocks scored against an arithmetic mean|x| model.
module tb_ref_lvl_ctrl;

  localparam int LOG2_N   = 4;
  localparam int N_SYM    = 1 << LOG2_N;
  localparam int ALPHA_SH = 3;
  localparam int REF_INIT = 43690;

  logic               clk = 1'b0;
  logic               reset;
  logic               sym_en;
  logic signed [17:0] dec_in;
  logic               start;
  logic               track;
  logic signed [17:0] ref_lvl;
  logic               ref_valid;
  logic               upd_pulse;
  logic               busy;

  int n_chk  = 0;
  int n_pass = 0;

  // reference model state
  int  m_ref   = REF_INIT;
  bit  m_valid = 1'b0;

  ref_lvl_ctrl #(.LOG2_N(LOG2_N), .REF_INIT(18'sd43690), .ALPHA_SH(ALPHA_SH)) dut (
    .clk(clk), .reset(reset), .sym_en(sym_en), .dec_in(dec_in), .start(start),
    .track(track), .ref_lvl(ref_lvl), .ref_valid(ref_valid), .upd_pulse(upd_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  function automatic int abs_sat(input int v);
    if (v == -131072) return 131071;
    return (v < 0) ? -v : v;
  endfunction

  function automatic void model_update(input int sum);
    int half;
    half = (sum / N_SYM) / 2;
`ifdef REF_LVL_IIR_EN
    if (!m_valid) m_ref = half;
    else          m_ref = m_ref + ((half - m_ref) >>> ALPHA_SH);
`else
    m_ref = half;
`endif
    m_valid = 1'b1;
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset   = 1'b1;
    m_ref   = REF_INIT;
    m_valid = 1'b0;
  endtask

  task automatic run_block(input string tag, input int vals[N_SYM], input bit use_start, input bit trk);
    int sum = 0;
    if (use_start) begin
      start = 1'b1;
      tick();
      start = 1'b0;
    end
    track = 1'($urandom);
    for (int i = 0; i < N_SYM; i++) begin
      sum   += abs_sat(vals[i]);
      sym_en = 1'b1;
      dec_in = 18'(vals[i]);
      tick();
      sym_en = 1'b0;
      dec_in = 18'($urandom);
      if (i == 8) begin
        track = trk;
        chk({tag, "_busy_acq"}, int'(busy), 1);
      end
      if (i < N_SYM - 1) repeat ($urandom_range(1, 3)) tick();
    end
    chk({tag, "_upd_early"}, int'(upd_pulse), 0);
    tick();
    model_update(sum);
    chk({tag, "_upd_pulse"}, int'(upd_pulse), 1);
    chk({tag, "_ref_lvl"}, int'(ref_lvl), m_ref);
    chk({tag, "_ref_valid"}, int'(ref_valid), 1);
    chk({tag, "_busy_after"}, int'(busy), int'(trk));
    tick();
    chk({tag, "_upd_once"}, int'(upd_pulse), 0);
  endtask

  initial begin
    int  vals[N_SYM];
    bit  seen_upd;
    bit  prev_trk;

    reset = 1'b1; sym_en = 1'b0; dec_in = '0; start = 1'b0; track = 1'b0;
    tick();
    apply_reset();
    chk("rst_ref_lvl", int'(ref_lvl), REF_INIT);
    chk("rst_valid", int'(ref_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_upd", int'(upd_pulse), 0);

    // strobes in IDLE must not be accumulated
    for (int i = 0; i < 5; i++) begin
      sym_en = 1'b1; dec_in = 18'sd131071; tick();
      sym_en = 1'b0; tick();
    end
    chk("idle_busy", int'(busy), 0);
    chk("idle_valid", int'(ref_valid), 0);

    for (int i = 0; i < N_SYM; i++) vals[i] = 131071;
    run_block("full", vals, 1'b1, 1'b0);
    chk("full_abs", int'(ref_lvl), 65535);

    for (int i = 0; i < N_SYM; i++) begin
      case (i % 4)
        0: vals[i] = 131071;
        1: vals[i] = 43691;
        2: vals[i] = -43691;
        default: vals[i] = -131072;
      endcase
    end
    run_block("mix", vals, 1'b1, 1'b0);

    for (int i = 0; i < N_SYM; i++) vals[i] = -131072;
    run_block("neg_sat", vals, 1'b1, 1'b0);

    // reset in the middle of a block
    start = 1'b1; tick(); start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sym_en = 1'b1; dec_in = 18'sd100000; tick();
      sym_en = 1'b0; tick();
    end
    apply_reset();
    chk("midrst_ref_lvl", int'(ref_lvl), REF_INIT);
    chk("midrst_valid", int'(ref_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    seen_upd = 1'b0;
    for (int i = 0; i < 20; i++) begin
      sym_en = 1'b1; dec_in = 18'sd131071; tick();
      sym_en = 1'b0;
      if (upd_pulse) seen_upd = 1'b1;
      tick();
      if (upd_pulse) seen_upd = 1'b1;
    end
    chk("midrst_no_upd", int'(seen_upd), 0);
    chk("midrst_hold", int'(ref_lvl), REF_INIT);

    // continuous tracking: second block starts without start
    for (int i = 0; i < N_SYM; i++) vals[i] = 43691;
    run_block("trk1", vals, 1'b1, 1'b1);
    for (int i = 0; i < N_SYM; i++) vals[i] = 131071;
    run_block("trk2", vals, 1'b0, 1'b0);

    prev_trk = 1'b0;
    for (int b = 0; b < 8; b++) begin
      bit trk;
      for (int i = 0; i < N_SYM; i++) vals[i] = int'($urandom_range(0, 262143)) - 131072;
      trk = 1'($urandom);
      if (b == 7) trk = 1'b0;
      run_block($sformatf("rnd%0d", b), vals, !prev_trk, trk);
      prev_trk = trk;
    end
    chk("end_idle_busy", int'(busy), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
